// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key-event decoder.
// The event record is what travels through the event FIFO.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rpt;
  } key_event_t;

  localparam int KEY_EVENT_W = $bits(key_event_t);

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead event FIFO: the head entry is always on o_data while not empty.
// A push on a full FIFO is accepted only when a pop frees a slot on the same edge.
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rdPtr;
  logic [AW-1:0]    r_wrPtr;
  logic [AW:0]      r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == FULL_CNT);
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);
  assign o_data   = r_mem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (w_doPush && !rst) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// Turns a stream of PS/2 scan bytes into make/break/repeat key events,
// tracks held keys and new-press statistics, and queues events in a FIFO.
module ps2_key_event_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8,
  parameter int MAX_HELD   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [7:0]                        in_data,
  output logic                              ev_valid,
  output logic [7:0]                        ev_code,
  output logic                              ev_ext,
  output logic                              ev_break,
  output logic                              ev_repeat,
  input  logic                              ev_pop,
  output logic                              overflow,
  output logic [CNT_W-1:0]                  press_count,
  output logic [$clog2(MAX_HELD+1)-1:0]     held_count,
  output logic [7:0]                        last_code,
  output logic                              last_ext
);

  localparam int HCW = $clog2(MAX_HELD + 1);
  localparam int IW  = (MAX_HELD > 1) ? $clog2(MAX_HELD) : 1;

  dec_state_t       r_state;
  logic [8:0]       r_slotKey [MAX_HELD];
  logic [MAX_HELD-1:0] r_slotValid;
  logic [HCW-1:0]   r_heldCount;
  logic [CNT_W-1:0] r_pressCount;
  logic [7:0]       r_lastCode;
  logic             r_lastExt;
  logic             r_overflow;

  dec_state_t       w_nextState;
  logic             w_isMake;
  logic             w_isBreak;
  logic             w_ext;
  logic [8:0]       w_key;
  logic             w_hit;
  logic [IW-1:0]    w_hitIdx;
  logic             w_hasFree;
  logic [IW-1:0]    w_freeIdx;
  logic             w_newPress;
  logic             w_release;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  key_event_t       w_event;
  key_event_t       w_head;

  // Prefix decoding: a key event completes on the byte that ends a sequence.
  always_comb begin
    w_nextState = r_state;
    w_isMake    = 1'b0;
    w_isBreak   = 1'b0;
    w_ext       = 1'b0;
    if (in_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (in_data == PS2_EXT) begin
            w_nextState = ST_EXT;
          end else if (in_data == PS2_BRK) begin
            w_nextState = ST_BRK;
          end else if (in_data != 8'h00 && in_data != 8'hFF) begin
            w_isMake = 1'b1;
          end
        end
        ST_EXT: begin
          if (in_data == PS2_BRK) begin
            w_nextState = ST_EXT_BRK;
          end else if (in_data != PS2_EXT) begin
            w_isMake    = 1'b1;
            w_ext       = 1'b1;
            w_nextState = ST_IDLE;
          end
        end
        ST_BRK: begin
          w_isBreak   = 1'b1;
          w_nextState = ST_IDLE;
        end
        ST_EXT_BRK: begin
          w_isBreak   = 1'b1;
          w_ext       = 1'b1;
          w_nextState = ST_IDLE;
        end
        default: w_nextState = ST_IDLE;
      endcase
    end
  end

  assign w_key = {w_ext, in_data};

  // Descending scan so the lowest matching / free slot wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hitIdx  = '0;
    w_hasFree = 1'b0;
    w_freeIdx = '0;
    for (int i = MAX_HELD - 1; i >= 0; i--) begin
      if (r_slotValid[i] && r_slotKey[i] == w_key) begin
        w_hit    = 1'b1;
        w_hitIdx = IW'(i);
      end
      if (!r_slotValid[i]) begin
        w_hasFree = 1'b1;
        w_freeIdx = IW'(i);
      end
    end
  end

  assign w_newPress = w_isMake && !w_hit;
  assign w_release  = w_isBreak && w_hit;
  assign w_push     = (w_isMake || w_isBreak) && !rst;
  assign w_event    = '{code: in_data, ext: w_ext, brk: w_isBreak, rpt: w_isMake && w_hit};

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_EVENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_event),
    .i_pop   (ev_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Table and statistics update regardless of whether the FIFO accepted the event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_slotValid  <= '0;
      r_heldCount  <= '0;
      r_pressCount <= '0;
      r_lastCode   <= '0;
      r_lastExt    <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_push && w_full && !ev_pop) begin
        r_overflow <= 1'b1;
      end
      if (w_newPress) begin
        r_pressCount <= r_pressCount + CNT_W'(1);
        r_lastCode   <= in_data;
        r_lastExt    <= w_ext;
        if (w_hasFree) begin
          r_slotValid[w_freeIdx] <= 1'b1;
          r_slotKey[w_freeIdx]   <= w_key;
          r_heldCount            <= r_heldCount + HCW'(1);
        end
      end
      if (w_release) begin
        r_slotValid[w_hitIdx] <= 1'b0;
        r_heldCount           <= r_heldCount - HCW'(1);
        if (r_heldCount == HCW'(1)) begin
          r_lastCode <= '0;
          r_lastExt  <= 1'b0;
        end
      end
    end
  end

  assign ev_valid    = !w_empty;
  assign ev_code     = w_head.code;
  assign ev_ext      = w_head.ext;
  assign ev_break    = w_head.brk;
  assign ev_repeat   = w_head.rpt;
  assign overflow    = r_overflow;
  assign press_count = r_pressCount;
  assign held_count  = r_heldCount;
  assign last_code   = r_lastCode;
  assign last_ext    = r_lastExt;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed bench for the PS/2 key-event decoder: expected events are queued as
// byte sequences are driven and checked as the consumer pops them.
module tb_ps2_key_event_decoder;

  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 8;
  localparam int MAX_HELD   = 4;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          in_valid;
  logic [7:0]                    in_data;
  logic                          ev_valid;
  logic [7:0]                    ev_code;
  logic                          ev_ext;
  logic                          ev_break;
  logic                          ev_repeat;
  logic                          ev_pop;
  logic                          overflow;
  logic [CNT_W-1:0]              press_count;
  logic [$clog2(MAX_HELD+1)-1:0] held_count;
  logic [7:0]                    last_code;
  logic                          last_ext;

  int          nCompared = 0;
  int          nFailed   = 0;
  logic [10:0] expQ [$];
  logic        expOverflow;

  ps2_key_event_decoder #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W),
    .MAX_HELD   (MAX_HELD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .ev_valid    (ev_valid),
    .ev_code     (ev_code),
    .ev_ext      (ev_ext),
    .ev_break    (ev_break),
    .ev_repeat   (ev_repeat),
    .ev_pop      (ev_pop),
    .overflow    (overflow),
    .press_count (press_count),
    .held_count  (held_count),
    .last_code   (last_code),
    .last_ext    (last_ext)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Caller is always at posedge+1; returns at posedge+1 after the byte is sampled.
  task automatic applyStimulus(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  // Called right after the edge that completes an event; the queue mirrors FIFO contents.
  task automatic expectEvent(input logic [7:0] code, input logic ext, input logic brk, input logic rpt);
    if (expQ.size() >= FIFO_DEPTH) begin
      expOverflow = 1'b1;
    end else begin
      expQ.push_back({code, ext, brk, rpt});
    end
  endtask

  task automatic doReset();
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    expOverflow = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while (expQ.size() != 0 && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_drain"}, expQ.size(), 0);
  endtask

  // Consumer-side scoreboard: presence and content of the head event.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("ev_valid", ev_valid, expQ.size() != 0);
      if (ev_valid && ev_pop && expQ.size() != 0) begin
        checkOutput("event", {ev_code, ev_ext, ev_break, ev_repeat}, expQ[0]);
        void'(expQ.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] keys [5];
    keys[0] = 8'h1C; keys[1] = 8'h32; keys[2] = 8'h21; keys[3] = 8'h23; keys[4] = 8'h24;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    ev_pop      = 1'b1;
    expOverflow = 1'b0;

    doReset();
    checkOutput("rst_ev_valid", ev_valid, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_press", press_count, 0);
    checkOutput("rst_held", held_count, 0);
    checkOutput("rst_last_code", last_code, 0);
    checkOutput("rst_last_ext", last_ext, 0);

    $display("[TB] plain make/break");
    applyStimulus(8'h1C); expectEvent(8'h1C, 0, 0, 0);
    checkOutput("mb_last_make", last_code, 8'h1C);
    checkOutput("mb_held_make", held_count, 1);
    applyStimulus(8'hF0); applyStimulus(8'h1C); expectEvent(8'h1C, 0, 1, 0);
    checkOutput("mb_press", press_count, 1);
    checkOutput("mb_last_brk", last_code, 0);
    checkOutput("mb_held_brk", held_count, 0);
    waitDrain("mb");

    $display("[TB] extended make/repeat/break");
    applyStimulus(8'hE0); applyStimulus(8'h75); expectEvent(8'h75, 1, 0, 0);
    checkOutput("ext_held1", held_count, 1);
    checkOutput("ext_last_code", last_code, 8'h75);
    checkOutput("ext_last_ext", last_ext, 1);
    applyStimulus(8'hE0); applyStimulus(8'h75); expectEvent(8'h75, 1, 0, 1);
    checkOutput("ext_held2", held_count, 1);
    checkOutput("ext_press_rpt", press_count, 2);
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75); expectEvent(8'h75, 1, 1, 0);
    checkOutput("ext_held3", held_count, 0);
    checkOutput("ext_press", press_count, 2);
    checkOutput("ext_last_ext_clr", last_ext, 0);
    waitDrain("ext");

    $display("[TB] filler bytes");
    applyStimulus(8'h00); applyStimulus(8'hFF);
    checkOutput("fill_press", press_count, 2);
    waitDrain("fill");

    $display("[TB] held table full");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(keys[i]); expectEvent(keys[i], 0, 0, 0);
    end
    checkOutput("full_press", press_count, 7);
    checkOutput("full_held", held_count, 4);
    checkOutput("full_last", last_code, 8'h24);
    applyStimulus(8'h1C); expectEvent(8'h1C, 0, 0, 1);
    checkOutput("full_rpt_press", press_count, 7);
    checkOutput("full_rpt_last", last_code, 8'h24);
    applyStimulus(8'hF0); applyStimulus(8'h1C); expectEvent(8'h1C, 0, 1, 0);
    checkOutput("full_rel1_held", held_count, 3);
    checkOutput("full_rel1_last", last_code, 8'h24);
    for (int i = 1; i < 5; i++) begin
      applyStimulus(8'hF0); applyStimulus(keys[i]); expectEvent(keys[i], 0, 1, 0);
    end
    checkOutput("full_rel_held", held_count, 0);
    checkOutput("full_rel_last", last_code, 0);
    checkOutput("full_rel_press", press_count, 7);
    waitDrain("full");

    $display("[TB] reset mid-prefix");
    applyStimulus(8'hE0); applyStimulus(8'hF0);
    doReset();
    applyStimulus(8'h1C); expectEvent(8'h1C, 0, 0, 0);
    checkOutput("rmp_press", press_count, 1);
    checkOutput("rmp_last_ext", last_ext, 0);
    waitDrain("rmp");
    applyStimulus(8'hF0); applyStimulus(8'h1C); expectEvent(8'h1C, 0, 1, 0);
    waitDrain("rmp_rel");

    $display("[TB] FIFO overflow");
    ev_pop = 1'b0;
    for (int i = 0; i <= FIFO_DEPTH; i++) begin
      applyStimulus(8'h1C); expectEvent(8'h1C, 0, 0, (i != 0));
    end
    checkOutput("ovf_flag", overflow, expOverflow);
    checkOutput("ovf_flag_set", overflow, 1);
    checkOutput("ovf_press", press_count, 2);
    checkOutput("ovf_qsize", expQ.size(), FIFO_DEPTH);
    ev_pop = 1'b1;
    applyStimulus(8'h1C); expectEvent(8'h1C, 0, 0, 1);
    waitDrain("ovf");
    applyStimulus(8'hF0); applyStimulus(8'h1C); expectEvent(8'h1C, 0, 1, 0);
    waitDrain("ovf_rel");

    $display("[TB] press counter wrap");
    doReset();
    for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
      applyStimulus(8'h1C); expectEvent(8'h1C, 0, 0, 0);
      applyStimulus(8'hF0); applyStimulus(8'h1C); expectEvent(8'h1C, 0, 1, 0);
    end
    checkOutput("wrap_max", press_count, (1 << CNT_W) - 1);
    applyStimulus(8'h1C); expectEvent(8'h1C, 0, 0, 0);
    checkOutput("wrap_zero", press_count, 0);
    checkOutput("wrap_held", held_count, 1);
    waitDrain("wrap");
    checkOutput("wrap_overflow", overflow, expOverflow);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
